// File: rtl/uart_prog_loader.sv
// UART programming-port feeder: receives 8N1 bytes, packs them little-endian into
// 32-bit words and writes them at sequential addresses until idle timeout or memory full.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int IDLE_BITS    = 32,
  parameter int DEPTH_WORDS  = 16384
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        rx_i,
  output logic [3:0]  upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        frame_err_o
);

  localparam int HALF_BIT   = CLKS_PER_BIT / 2;
  localparam int CNT_W      = $clog2(CLKS_PER_BIT + 1);
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [13:0] LAST_ADR = 14'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   clk_cnt, clk_cnt_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [7:0]         shift;
  logic               shift_en, byte_vld, byte_bad, start_det;
  logic               rx_sync_p0, rx_sync_p1;
  logic [1:0]         lane;
  logic [31:0]        word_buf;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               seen, idle_run, timeout;

  // Stage p0/p1: two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_i;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (shift_en) shift <= {rx_sync_p1, shift[7:1]};
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + CNT_W'(1);
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    byte_vld    = 1'b0;
    byte_bad    = 1'b0;
    start_det   = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_sync_p1) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch
        if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_sync_p1 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt = '0;
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (rx_sync_p1) byte_vld = 1'b1;
          else            byte_bad = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idle_run = (state == IDLE) && seen && !upg_done_o && (upg_wen_o == 4'd0);
  assign timeout  = idle_run && (idle_cnt == IDLE_W'(IDLE_LIMIT - 1));

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      lane        <= '0;
      word_buf    <= '0;
      idle_cnt    <= '0;
      seen        <= 1'b0;
      upg_wen_o   <= '0;
      upg_adr_o   <= '0;
      upg_dat_o   <= '0;
      upg_done_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (byte_bad) frame_err_o <= 1'b1;
      if (start_det || byte_vld) idle_cnt <= '0;
      else if (idle_run)         idle_cnt <= idle_cnt + IDLE_W'(1);

      if (upg_wen_o != 4'd0) begin
        // A partial (flush) write or a write to the last word ends the load
        upg_wen_o <= '0;
        if (upg_wen_o != 4'hF || upg_adr_o == LAST_ADR) upg_done_o <= 1'b1;
        else                                            upg_adr_o  <= upg_adr_o + 14'd1;
      end else if (!upg_done_o) begin
        if (byte_vld) begin
          seen                      <= 1'b1;
          lane                      <= lane + 2'd1;
          word_buf[{lane, 3'b000} +: 8] <= shift;
          if (lane == 2'd3) begin
            upg_wen_o <= 4'hF;
            upg_dat_o <= {shift, word_buf[23:0]};
            word_buf  <= '0;
          end
        end else if (timeout) begin
          if (lane != 2'd0) begin
            upg_wen_o <= (4'd1 << lane) - 4'd1;
            upg_dat_o <= word_buf;
            word_buf  <= '0;
            lane      <= '0;
          end else begin
            upg_done_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder of the data-memory UART programming port.
- Receives a raw 8N1 UART byte stream and packs bytes little-endian into 32-bit words.
- Drives word writes with byte enables at sequential word addresses.
- Asserts done after an idle timeout or when memory is full, which returns the CPU to normal mode.

Parameters:
- CLKS_PER_BIT, 87: upg_clk_i cycles per UART bit (10 MHz / 115200 baud).
- IDLE_BITS, 32: idle bit-times after the last byte before the load is declared complete.
- DEPTH_WORDS, 16384: number of word addresses; the last address is DEPTH_WORDS-1.

Ports:
- upg_clk_i  input  1  loader clock, rising edge.
- upg_rst_i  input  1  asynchronous active-high reset.
- rx_i  input  1  UART serial input, asynchronous, idles high.
- upg_wen_o  output  4  byte write enables; nonzero for exactly one cycle per write.
- upg_adr_o  output  14  word address of the current write.
- upg_dat_o  output  32  write data; byte k of the word is bits [8k+7:8k].
- upg_done_o  output  1  load complete; sticky until reset.
- frame_err_o  output  1  sticky flag: at least one byte was dropped for a bad stop bit.

Behaviour:
- Reset values (asynchronous): upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, frame_err_o=0. Byte lane counter=0, idle counter=0, rx FSM=IDLE, "any byte seen" flag=0.
- Reset asserted mid-frame or mid-word discards all partial state; there is no write on reset.
- rx_i passes through a 2-FF synchronizer, initialised to 1. All sampling uses the synchronized value.
- RX FSM states:
  - IDLE: on synced rx=0 -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 cycles, re-sample. If 0 -> DATA. If 1 (glitch) -> IDLE, no byte produced.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, the byte is accepted. If 0, the byte is dropped and frame_err_o set. Either way -> IDLE.
- Byte packing:
  - An accepted byte is written into lane L (0..3) of the word buffer; L increments.
  - When L wraps 3->0, a write issues on the next cycle: upg_wen_o=4'b1111, upg_dat_o=buffer, upg_adr_o=current address.
  - In the cycle after the write, the address increments and the buffer is cleared to 0.
- Idle timeout:
  - The idle counter resets on every accepted byte and on any rx start-bit detection.
  - It counts cycles only while the FSM is IDLE, the "any byte seen" flag is 1, and done=0.
  - On reaching IDLE_BITS*CLKS_PER_BIT:
    - If L!=0, flush one partial write: upg_wen_o has bits [L-1:0] set, unreceived lanes are 0, address = current address.
    - Then set upg_done_o on the following cycle.
    - If L==0, set upg_done_o directly.
- Full: the write to address DEPTH_WORDS-1 sets upg_done_o on the next cycle. The address does not wrap.
- After done=1:
  - The RX FSM keeps running but accepted bytes are ignored.
  - No further writes occur; upg_wen_o holds 0.
  - upg_adr_o and upg_dat_o hold their last values.
- No timeout occurs before the first byte: an unconnected line never produces done.
- A frame error does not advance L; packing continues with the next good byte.

Test Plan:
- Send bytes 0x78,0x56,0x34,0x12 -> exactly one cycle with upg_wen_o=4'hF, upg_adr_o=0, upg_dat_o=0x12345678. After IDLE_BITS bit-times, upg_done_o=1 with no extra write.
- Send 8 bytes 00..07 -> writes (adr0, 0x03020100) and (adr1, 0x07060504). upg_adr_o=2 after the second write; done after timeout.
- Send 6 bytes AA BB CC DD EE FF then idle -> second write has upg_wen_o=4'b0011, upg_adr_o=1, upg_dat_o=0x0000FFEE. Then done.
- A 0.3-bit low glitch on rx_i, then byte 0x5A with stop bit forced 0, then 0x11 0x22 0x33 0x44 -> no byte from the glitch, frame_err_o=1, single write 0x44332211 at adr 0.
- DEPTH_WORDS=2, send 12 bytes -> writes at adr 0 and 1 only; upg_done_o=1 one cycle after the adr-1 write; the remaining bytes produce no write.
- Assert upg_rst_i after 2 bytes of a word, release, then send 4 bytes 01 02 03 04 -> all outputs 0 during reset, then one write 0x04030201 at adr 0, frame_err_o=0.
